// File: rtl/branch_pc_unit.sv
// Fetch PC sequencer with a 2-bit saturating branch history table.
// Commit-time mispredicts redirect the PC, raise a registered flush and bump a saturating counter.
module branch_pc_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             queue_full,
  input  logic [31:0]      fetch_instr,
  input  logic             fetch_branch,
  input  logic             fetch_jump,
  input  logic             commit_valid,
  input  logic             commit_is_branch,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [XLEN-1:0]  commit_imm_se,
  input  logic             commit_pred_taken,
  input  logic             commit_actual_taken,
  output logic [XLEN-1:0]  pc,
  output logic             predict_taken,
  output logic             mispredict_flush,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned B_W   = 13;
  localparam int unsigned J_W   = 21;

  logic [1:0]      bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] commit_idx;
  logic [1:0]      commit_ctr;
  logic            bht_update;
  logic            mis;
  logic [XLEN-1:0] b_imm;
  logic [XLEN-1:0] j_imm;
  logic [XLEN-1:0] pc_next;
  logic            unused_opcode;

  assign fetch_idx     = pc[IDX_W+1:2];
  assign commit_idx    = commit_pc[IDX_W+1:2];
  assign commit_ctr    = bht[commit_idx];
  assign bht_update    = commit_valid & commit_is_branch;
  assign mis           = bht_update & (commit_pred_taken ^ commit_actual_taken);
  assign predict_taken = fetch_branch & bht[fetch_idx][1];
  assign unused_opcode = ^fetch_instr[6:0];

  assign b_imm = {{(XLEN-B_W){fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                  fetch_instr[30:25], fetch_instr[11:8], 1'b0};
  assign j_imm = {{(XLEN-J_W){fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                  fetch_instr[20], fetch_instr[30:21], 1'b0};

  // Commit redirects outrank a stall; fetch-side targets only apply when not stalled.
  always_comb begin
    pc_next = pc + XLEN'(4);
    if (mis && commit_actual_taken) begin
      pc_next = commit_pc + commit_imm_se;
    end else if (mis) begin
      pc_next = commit_pc + XLEN'(4);
    end else if (queue_full) begin
      pc_next = pc;
    end else if (predict_taken) begin
      pc_next = pc + b_imm;
    end else if (fetch_jump) begin
      pc_next = pc + j_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc               <= RESET_PC;
      mispredict_flush <= 1'b0;
      mispredict_count <= '0;
    end else begin
      pc               <= pc_next;
      mispredict_flush <= mis;
      if (mis && (mispredict_count != {CNT_W{1'b1}})) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  // Training happens only at commit; fetch reads in the same cycle see the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht[i] <= 2'b01;
      end
    end else if (bht_update) begin
      if (commit_actual_taken && (commit_ctr != 2'b11)) begin
        bht[commit_idx] <= commit_ctr + 2'd1;
      end else if (!commit_actual_taken && (commit_ctr != 2'b00)) begin
        bht[commit_idx] <= commit_ctr - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed vector table, hand sequences, then random stimulus vs. a model.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        queue_full;
  logic [31:0] fetch_instr;
  logic        fetch_branch;
  logic        fetch_jump;
  logic        commit_valid;
  logic        commit_is_branch;
  logic [31:0] commit_pc;
  logic [31:0] commit_imm_se;
  logic        commit_pred_taken;
  logic        commit_actual_taken;
  logic [31:0] pc, pc2;
  logic        predict_taken, pred2;
  logic        mispredict_flush, flush2;
  logic [15:0] mispredict_count;
  logic [1:0]  cnt2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.XLEN(32), .BHT_ENTRIES(16), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .queue_full(queue_full), .fetch_instr(fetch_instr),
    .fetch_branch(fetch_branch), .fetch_jump(fetch_jump), .commit_valid(commit_valid),
    .commit_is_branch(commit_is_branch), .commit_pc(commit_pc), .commit_imm_se(commit_imm_se),
    .commit_pred_taken(commit_pred_taken), .commit_actual_taken(commit_actual_taken),
    .pc(pc), .predict_taken(predict_taken), .mispredict_flush(mispredict_flush),
    .mispredict_count(mispredict_count)
  );

  branch_pc_unit #(.XLEN(32), .BHT_ENTRIES(16), .RESET_PC(32'h0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .queue_full(queue_full), .fetch_instr(fetch_instr),
    .fetch_branch(fetch_branch), .fetch_jump(fetch_jump), .commit_valid(commit_valid),
    .commit_is_branch(commit_is_branch), .commit_pc(commit_pc), .commit_imm_se(commit_imm_se),
    .commit_pred_taken(commit_pred_taken), .commit_actual_taken(commit_actual_taken),
    .pc(pc2), .predict_taken(pred2), .mispredict_flush(flush2),
    .mispredict_count(cnt2)
  );

  typedef struct {
    logic        qf;
    logic [31:0] instr;
    logic        br, jp, cv, cb;
    logic [31:0] cpc, cimm;
    logic        cp, ca;
    logic        exp_pred;
    logic [31:0] exp_pc;
    logic        exp_flush;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic qf, logic [31:0] instr, logic br, logic jp, logic cv, logic cb,
                              logic [31:0] cpc, logic [31:0] cimm, logic cp, logic ca,
                              logic exp_pred, logic [31:0] exp_pc, logic exp_flush, int exp_cnt);
    vec_t v;
    v.qf = qf; v.instr = instr; v.br = br; v.jp = jp; v.cv = cv; v.cb = cb;
    v.cpc = cpc; v.cimm = cimm; v.cp = cp; v.ca = ca;
    v.exp_pred = exp_pred; v.exp_pc = exp_pc; v.exp_flush = exp_flush; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  function automatic vec_t idle(logic [31:0] exp_pc, int exp_cnt);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp_pc, 0, exp_cnt);
  endfunction

  function automatic int sat(int n, int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(vec_t v);
    queue_full = v.qf; fetch_instr = v.instr; fetch_branch = v.br; fetch_jump = v.jp;
    commit_valid = v.cv; commit_is_branch = v.cb; commit_pc = v.cpc; commit_imm_se = v.cimm;
    commit_pred_taken = v.cp; commit_actual_taken = v.ca;
  endtask

  task automatic check_regs(string name, logic [31:0] epc, logic ef, int ecnt);
    chk({name, ".pc"}, 64'(pc), 64'(epc));
    chk({name, ".pc2"}, 64'(pc2), 64'(epc));
    chk({name, ".flush"}, 64'(mispredict_flush), 64'(ef));
    chk({name, ".flush2"}, 64'(flush2), 64'(ef));
    chk({name, ".count"}, 64'(mispredict_count), 64'(sat(ecnt, 65535)));
    chk({name, ".count2"}, 64'(cnt2), 64'(sat(ecnt, 3)));
  endtask

  // Apply one vector: prediction sampled mid-cycle, registered outputs sampled after the edge.
  task automatic run_vec(vec_t v, string name);
    drive(v);
    @(negedge clk);
    chk({name, ".pred"}, 64'(predict_taken), 64'(v.exp_pred));
    chk({name, ".pred2"}, 64'(pred2), 64'(v.exp_pred));
    @(posedge clk);
    #1;
    check_regs(name, v.exp_pc, v.exp_flush, v.exp_cnt);
  endtask

  function automatic int b_off(logic [31:0] i);
    return int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 - int'(i[31]) * 4096;
  endfunction

  function automatic int j_off(logic [31:0] i);
    return int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2 - int'(i[31]) * 1048576;
  endfunction

  localparam logic [31:0] BEQ16 = 32'h0000_0863;  // branch, offset +16
  localparam logic [31:0] JALM12 = 32'hFF5F_F06F; // jal, offset -12

  logic [31:0] m_pc;
  int          m_bht [16];
  logic        m_flush;
  int          m_cnt;

  initial begin
    rst = 1'b1;
    drive(idle(0, 0));
    fetch_branch = 1'b1;
    #12;
    chk("reset.pc", 64'(pc), 64'h0);
    chk("reset.flush", 64'(mispredict_flush), 64'h0);
    chk("reset.count", 64'(mispredict_count), 64'h0);
    chk("reset.pred", 64'(predict_taken), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    vecs.push_back(idle(32'h04, 0));
    vecs.push_back(idle(32'h08, 0));
    vecs.push_back(idle(32'h0C, 0));
    vecs.push_back(idle(32'h10, 0));
    vecs.push_back(mk(0, BEQ16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h14, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h10, 0, 1, 1, 0, 32'h18, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h10, 0, 1, 1, 0, 32'h1C, 0, 0));
    vecs.push_back(mk(0, JALM12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0));
    vecs.push_back(mk(0, BEQ16, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0));
    vecs.push_back(idle(32'h24, 0));
    vecs.push_back(idle(32'h28, 0));
    vecs.push_back(idle(32'h2C, 0));
    vecs.push_back(idle(32'h30, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h30, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h30, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h30, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 32'h40, 32'h100, 0, 1, 0, 32'h140, 1, 1));
    vecs.push_back(idle(32'h144, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h80, 32'h40, 1, 0, 0, 32'h84, 1, 2));
    vecs.push_back(idle(32'h88, 2));
    vecs.push_back(mk(1, BEQ16, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h88, 0, 2));
    vecs.push_back(mk(0, BEQ16, 1, 0, 1, 1, 32'h08, 0, 1, 1, 0, 32'h8C, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h100, 32'h40, 0, 1, 0, 32'h90, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h100, 32'h40, 0, 1, 0, 32'h94, 0, 2));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // PC wrap and counter saturation on back-to-back mispredicts.
    run_vec(mk(0, 0, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 1, 0, 0, 32'hFFFF_FFFC, 1, 3), "wrap_setup");
    run_vec(idle(32'h0, 3), "wrap");
    for (int k = 0; k < 5; k++)
      run_vec(mk(0, 0, 0, 0, 1, 1, 32'h300, 0, 1, 0, 0, 32'h304, 1, 4 + k), $sformatf("sat%0d", k));

    // Asynchronous reset between edges while a flush is pending.
    run_vec(mk(0, 0, 0, 0, 1, 1, 32'h1FC, 0, 1, 0, 0, 32'h200, 1, 9), "pre_rst");
    drive(idle(0, 0));
    #1 rst = 1'b1;
    #1;
    check_regs("async_rst", 32'h0, 1'b0, 0);
    #1 rst = 1'b0;
    chk("post_release.pc", 64'(pc), 64'h0);
    run_vec(idle(32'h04, 0), "first_fetch");

    // Random phase against the model, starting from the freshly reset state.
    m_pc = 32'h4; m_flush = 1'b0; m_cnt = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      logic mis, mpred;
      int fi, ci;
      v = idle(0, 0);
      v.qf    = ($urandom_range(0, 3) == 0);
      v.instr = $urandom;
      v.br    = ($urandom_range(0, 9) < 3);
      v.jp    = ($urandom_range(0, 9) == 0);
      v.cv    = $urandom_range(0, 1) == 1;
      v.cb    = ($urandom_range(0, 9) < 7);
      v.cpc   = 32'($urandom_range(0, 63)) << 2;
      v.cimm  = (32'($urandom_range(0, 255)) << 2) - 32'd512;
      v.cp    = $urandom_range(0, 1) == 1;
      v.ca    = ($urandom_range(0, 3) == 0) ? ~v.cp : v.cp;
      drive(v);

      fi    = int'(m_pc / 4) % 16;
      mpred = v.br && (m_bht[fi] >= 2);
      mis   = v.cv && v.cb && (v.cp != v.ca);
      @(negedge clk);
      chk($sformatf("rnd%0d.pred", n), 64'(predict_taken), 64'(mpred));

      if (mis)           m_pc = v.ca ? v.cpc + v.cimm : v.cpc + 32'd4;
      else if (v.qf)     m_pc = m_pc;
      else if (mpred)    m_pc = m_pc + 32'(b_off(v.instr));
      else if (v.jp)     m_pc = m_pc + 32'(j_off(v.instr));
      else               m_pc = m_pc + 32'd4;
      if (v.cv && v.cb) begin
        ci = int'(v.cpc / 4) % 16;
        if (v.ca) m_bht[ci] = (m_bht[ci] == 3) ? 3 : m_bht[ci] + 1;
        else      m_bht[ci] = (m_bht[ci] == 0) ? 0 : m_bht[ci] - 1;
      end
      m_flush = mis;
      if (mis) m_cnt++;

      @(posedge clk);
      #1;
      check_regs($sformatf("rnd%0d", n), m_pc, m_flush, m_cnt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
